rc_serial_add: RTL and testbench

- Bit-serial signed ripple-carry adder that produces a WIDTH-bit two's-complement sum over WIDTH clocks, one bit per clock through a single full-adder cell.
- Sits directly upstream of the team's combinational signed-overflow validity check. It presents that check's three inputs (a_sb, b_sb, sum_sb) as registered outputs.
- It also computes and registers the same validity result itself, so datapath users need no extra glue.

---
 rtl/rc_pkg.sv | 17 +
 rtl/rc_fa_cell.sv | 13 +
 rtl/rc_serial_add.sv | 109 ++++++++++
 tb/tb_rc_serial_add.sv | 135 +++++++++++++
 4 files changed

// File: rtl/rc_pkg.sv
// rtl/rc_pkg.sv - shared state encoding, default width and signed-overflow validity rule
package rc_pkg;

  localparam int RC_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } rc_state_e;

  // Overflow only when both operand signs agree and the sum sign differs from them.
  function automatic logic rc_valid(input logic a_sb, input logic b_sb, input logic sum_sb);
    return !((a_sb == b_sb) && (b_sb != sum_sb));
  endfunction

endpackage

// File: rtl/rc_fa_cell.sv
// rtl/rc_fa_cell.sv - single-bit combinational full adder
module rc_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rc_serial_add.sv
// rtl/rc_serial_add.sv - bit-serial signed adder, one bit per clock; RC_SERIAL_SUB_EN adds a subtract port
module rc_serial_add
  import rc_pkg::*;
#(
  parameter  int WIDTH = RC_DEFAULT_WIDTH,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef RC_SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             a_sb,
  output logic             b_sb,
  output logic             sum_sb,
  output logic             valid
);

  rc_state_e        state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             fa_s;
  logic             fa_cout;
  logic             sub_eff;

`ifdef RC_SERIAL_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  rc_fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      sum    <= '0;
      a_sb   <= 1'b0;
      b_sb   <= 1'b0;
      sum_sb <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      valid  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1; b_sb carries the effective operand sign.
            a_sr  <= a;
            b_sr  <= sub_eff ? ~b : b;
            carry <= sub_eff;
            cnt   <= '0;
            a_sb  <= a[WIDTH-1];
            b_sb  <= b[WIDTH-1] ^ sub_eff;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          acc   <= {fa_s, acc[WIDTH-1:1]};
          carry <= fa_cout;
          if (cnt == CW'(WIDTH - 1)) begin
            sum    <= {fa_s, acc[WIDTH-1:1]};
            sum_sb <= fa_s;
            valid  <= rc_valid(a_sb, b_sb, fa_s);
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc_serial_add.sv
// tb/tb_rc_serial_add.sv - directed self-checking bench for rc_serial_add (WIDTH=8)
module tb_rc_serial_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, a_sb, b_sb, sum_sb, valid;
  logic [7:0] sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rc_serial_add #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef RC_SERIAL_SUB_EN
    .sub    (sub),
`endif
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .a_sb   (a_sb),
    .b_sb   (b_sb),
    .sum_sb (sum_sb),
    .valid  (valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts an operation, then walks cycles 1..12 after the accepting edge.
  // Stray start pulses (with a=b=50) are driven at cycles p1/p2.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input int p1, input int p2,
                        input logic [7:0] e_sum, input logic e_asb, input logic e_bsb,
                        input logic e_ssb, input logic e_valid);
    int done_cyc = 0;
    int ndone = 0;
    int busy_bad = 0;
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (busy !== ((c <= 9) ? 1'b1 : 1'b0)) busy_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == p1 || c == p2) begin
        a = 8'd50; b = 8'd50; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (c == 9) begin
        check({tag, "_sum"}, 32'(sum), 32'(e_sum));
        check({tag, "_a_sb"}, 32'(a_sb), 32'(e_asb));
        check({tag, "_b_sb"}, 32'(b_sb), 32'(e_bsb));
        check({tag, "_sum_sb"}, 32'(sum_sb), 32'(e_ssb));
        check({tag, "_valid"}, 32'(valid), 32'(e_valid));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'd9);
    check({tag, "_done_count"}, 32'(ndone), 32'd1);
    check({tag, "_busy_profile"}, 32'(busy_bad), 32'd0);
    check({tag, "_sum_held"}, 32'(sum), 32'(e_sum));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sum"}, 32'(sum), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_a_sb"}, 32'(a_sb), 32'h0);
    check({tag, "_b_sb"}, 32'(b_sb), 32'h0);
    check({tag, "_sum_sb"}, 32'(sum_sb), 32'h0);
    check({tag, "_valid"}, 32'(valid), 32'h1);
  endtask

  initial begin
    int seen_done;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_127",  8'd100, 8'd27,  1'b0, 0, 0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("pos_ovf",  8'd100, 8'd28,  1'b0, 0, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("neg_ovf",  8'h80,  8'hFF,  1'b0, 0, 0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("mixed",    8'hFB,  8'h03,  1'b0, 0, 0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b1);
    run_op("ignored",  8'd1,   8'd1,   1'b0, 3, 8, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of an operation.
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    check("midreset_no_done", 32'(seen_done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("after_rst", 8'd1, 8'd2, 1'b0, 0, 0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef RC_SERIAL_SUB_EN
    run_op("sub_minneg", 8'd0,  8'h80, 1'b1, 0, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sub_10_3",   8'd10, 8'd3,  1'b1, 0, 0, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
